bist_signature_checker: RTL and testbench
=========================================

Name: bist_signature_checker

Overview:
- BIST controller and result checker placed directly downstream of the pattern-counter / signature-analyser pair.
- On `start` it holds the counter and analyser in reset, then releases them for exactly TEST_LEN analyser clock edges.
- It then captures the analyser's parallel signature and compares it with a golden value.
- It reports pass/fail and keeps saturating pass/fail tallies across repeated runs.

Parameters:
- SIG_W, 4, width of the signature bus from the analyser.
- TEST_LEN, 16, number of analyser clock edges after release before capture (legal range 1..1023).
- GOLDEN, 4'h0, expected signature (SIG_W bits).
- TALLY_W, 8, width of the pass/fail run counters.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset; one clock, no other resets.
- start  input  1  level-sampled request to begin a run; acted on only in IDLE or DONE.
- sig_in  input  SIG_W  parallel signature from the analyser.
- cut_rst  output  1  registered, active-high reset driven to the counter and analyser.
- busy  output  1  high in CLEAR and RUN.
- done  output  1  high in DONE.
- pass  output  1  high in DONE when captured_sig == GOLDEN.
- fail  output  1  high in DONE when captured_sig != GOLDEN.
- captured_sig  output  SIG_W  signature latched at the end of RUN.
- pass_cnt  output  TALLY_W  saturating count of passing runs.
- fail_cnt  output  TALLY_W  saturating count of failing runs.

Behaviour:
- Reset (rst low, asynchronous) forces:
  - state = IDLE, cut_rst = 1
  - busy = done = pass = fail = 0
  - captured_sig = 0, pass_cnt = fail_cnt = 0, run_cnt = 0
- Reset mid-run aborts the run immediately; no tally update occurs.
- States: IDLE, CLEAR, RUN, DONE. Every output is registered; nothing combinational reaches a port.
- IDLE: cut_rst = 1. If start = 1 at an edge, go to CLEAR.
- CLEAR (exactly 1 cycle):
  - cut_rst stays 1, so the analyser sees a full cycle of reset.
  - run_cnt <= 0; pass and fail clear. Captured_sig and the tallies hold until the next capture.
  - Next state is RUN.
- RUN:
  - cut_rst = 0. run_cnt increments by 1 per cycle, so the cycle with run_cnt = k presents sig_in after k analyser edges.
  - When run_cnt == TEST_LEN at an edge:
    - captured_sig <= sig_in
    - pass <= (sig_in == GOLDEN); fail <= inverse
    - increment the matching tally, saturating at all-ones with no wrap
    - go to DONE
  - run_cnt width is clog2(TEST_LEN+1).
- DONE:
  - cut_rst = 1, done = 1; pass, fail and captured_sig hold.
  - start = 1 goes to CLEAR: done, pass and fail drop the next cycle, enabling back-to-back runs with no IDLE visit.
- start is ignored in CLEAR and RUN; no restart and no abort.
- start held high continuously re-runs on every DONE.
- Latency: done rises TEST_LEN+2 rising edges after the edge that samples start in IDLE.
- Width: comparison is over all SIG_W bits. GOLDEN is truncated or zero-extended to SIG_W.
- pass and fail are mutually exclusive and never high outside DONE.

Test Plan:
- Reset and idle:
  - Stimulus: rst low with start and sig_in toggling, then release.
  - Required: cut_rst = 1; busy = done = pass = fail = 0; captured_sig = 0; both tallies = 0 throughout.
- Pass path (TEST_LEN = 16, GOLDEN = 4'h0):
  - Stimulus: bench models sig_in as a 4-bit count of edges since cut_rst fell; one start pulse.
  - Required: cut_rst low for exactly 17 cycles; done high 18 edges after start; captured_sig = 4'h0; pass = 1; pass_cnt = 1.
- Fail path:
  - Stimulus: same stimulus with GOLDEN = 4'h5.
  - Required: captured_sig = 4'h0; fail = 1, pass = 0; fail_cnt = 1, pass_cnt = 0.
- Mid-run events:
  - Stimulus: start re-asserted during RUN; separately, rst pulsed low at run_cnt = 8.
  - Required: start is ignored, with timing identical to the pass-path case. The rst pulse returns the block to IDLE with cut_rst = 1 and tallies = 0; the next run completes normally.
- Back-to-back and saturation:
  - Stimulus: start held high with TALLY_W = 2, GOLDEN matching, for 5 runs.
  - Required: each DONE goes straight to CLEAR, with done high for 1 cycle per run. pass_cnt reads 1, 2, 3, 3, 3.
- Integration:
  - Stimulus: drive the team's counter + signature analyser pair via cut_rst and feed its signature into sig_in, with GOLDEN set to the value from the bench's software model after 16 edges.
  - Required: pass = 1, repeatable across 3 runs.

Source files
------------

// File: rtl/bist_signature_checker.sv
// BIST run controller: resets the pattern counter/analyser, runs TEST_LEN edges, checks the signature.
// Latency: done rises TEST_LEN+2 edges after start is sampled in IDLE; all ports registered.
// No backpressure: start is a level request honoured only in IDLE or DONE, ignored while busy.
module bist_signature_checker #(
  parameter int                SIG_W    = 4,
  parameter int                TEST_LEN = 16,
  parameter logic [SIG_W-1:0]  GOLDEN   = 4'h0,
  parameter int                TALLY_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SIG_W-1:0]   sig_in,
  output logic               cut_rst,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic [SIG_W-1:0]   captured_sig,
  output logic [TALLY_W-1:0] pass_cnt,
  output logic [TALLY_W-1:0] fail_cnt
);

  localparam int                 CNT_W = $clog2(TEST_LEN + 1);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(TEST_LEN);
  localparam logic [CNT_W-1:0]   C_ONE = CNT_W'(1);
  localparam logic [TALLY_W-1:0] T_ONE = TALLY_W'(1);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] run_cnt;
  logic             match;

  assign match = (sig_in == GOLDEN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cut_rst      <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      captured_sig <= '0;
      pass_cnt     <= '0;
      fail_cnt     <= '0;
      run_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= CLEAR;
            busy  <= 1'b1;
          end
        end
        // cut_rst is still high here, giving the analyser one full reset cycle.
        CLEAR: begin
          state   <= RUN;
          cut_rst <= 1'b0;
          run_cnt <= '0;
          pass    <= 1'b0;
          fail    <= 1'b0;
        end
        // run_cnt = k means sig_in reflects k analyser edges since release.
        RUN: begin
          if (run_cnt == LAST) begin
            state        <= DONE;
            cut_rst      <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b1;
            captured_sig <= sig_in;
            pass         <= match;
            fail         <= !match;
            if (match) begin
              if (pass_cnt != '1) pass_cnt <= pass_cnt + T_ONE;
            end else begin
              if (fail_cnt != '1) fail_cnt <= fail_cnt + T_ONE;
            end
          end else begin
            run_cnt <= run_cnt + C_ONE;
          end
        end
        DONE: begin
          if (start) begin
            state <= CLEAR;
            busy  <= 1'b1;
            done  <= 1'b0;
            pass  <= 1'b0;
            fail  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_signature_checker.sv
// Bench for bist_signature_checker: four instances (pass, fail, saturating tally, analyser integration)
// with a per-instance expected-result queue drained by a monitor on each rising done.
module tb_bist_signature_checker;

  function automatic logic [3:0] misr_model(input int n);
    logic [3:0] s;
    s = 4'h0;
    for (int c = 0; c < n; c++) s = {s[2:0], 1'b0} ^ (s[3] ? 4'h3 : 4'h0) ^ 4'(c);
    return s;
  endfunction

  localparam logic [3:0] INT_GOLD = misr_model(16);

  typedef struct {
    logic [3:0] sig;
    logic       pass;
    logic       fail;
    logic [7:0] pcnt;
    logic [7:0] fcnt;
    int         done_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_pf = 1'b0, start_sat = 1'b0, start_int = 1'b0;
  logic [3:0] noise = 4'h0;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  logic       cut_v [4], busy_v [4], done_v [4], pass_v [4], fail_v [4];
  logic [3:0] cap_v [4];
  logic [7:0] pc_v [4], fc_v [4];
  logic [1:0] pc_sat, fc_sat;
  logic [3:0] cnt_v [3];
  logic [3:0] acnt, misr;
  logic [3:0] sig_pass, sig_fail;

  exp_t exp_q [4][$];
  int   lo_cnt [4];
  logic done_q [4];

  assign pc_v[2]  = {6'b0, pc_sat};
  assign fc_v[2]  = {6'b0, fc_sat};
  assign sig_pass = cnt_v[0] ^ noise;
  assign sig_fail = cnt_v[1] ^ noise;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pattern models: edge counters and a counter-fed MISR, all held clear by each instance's cut_rst.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) cnt_v[i] <= cut_v[i] ? 4'h0 : cnt_v[i] + 4'h1;
    if (cut_v[3]) begin
      acnt <= 4'h0;
      misr <= 4'h0;
    end else begin
      acnt <= acnt + 4'h1;
      misr <= {misr[2:0], 1'b0} ^ (misr[3] ? 4'h3 : 4'h0) ^ acnt;
    end
  end

  bist_signature_checker #(.SIG_W(4), .TEST_LEN(16), .GOLDEN(4'h0), .TALLY_W(8)) u_pass (
    .clk(clk), .rst(rst), .start(start_pf), .sig_in(sig_pass), .cut_rst(cut_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .pass(pass_v[0]), .fail(fail_v[0]), .captured_sig(cap_v[0]),
    .pass_cnt(pc_v[0]), .fail_cnt(fc_v[0]));

  bist_signature_checker #(.SIG_W(4), .TEST_LEN(16), .GOLDEN(4'h5), .TALLY_W(8)) u_fail (
    .clk(clk), .rst(rst), .start(start_pf), .sig_in(sig_fail), .cut_rst(cut_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .pass(pass_v[1]), .fail(fail_v[1]), .captured_sig(cap_v[1]),
    .pass_cnt(pc_v[1]), .fail_cnt(fc_v[1]));

  bist_signature_checker #(.SIG_W(4), .TEST_LEN(16), .GOLDEN(4'h0), .TALLY_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(start_sat), .sig_in(cnt_v[2]), .cut_rst(cut_v[2]), .busy(busy_v[2]),
    .done(done_v[2]), .pass(pass_v[2]), .fail(fail_v[2]), .captured_sig(cap_v[2]),
    .pass_cnt(pc_sat), .fail_cnt(fc_sat));

  bist_signature_checker #(.SIG_W(4), .TEST_LEN(16), .GOLDEN(INT_GOLD), .TALLY_W(8)) u_int (
    .clk(clk), .rst(rst), .start(start_int), .sig_in(misr), .cut_rst(cut_v[3]), .busy(busy_v[3]),
    .done(done_v[3]), .pass(pass_v[3]), .fail(fail_v[3]), .captured_sig(cap_v[3]),
    .pass_cnt(pc_v[3]), .fail_cnt(fc_v[3]));

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h want %0h (cycle %0d)", nm, idx, act, req, cyc);
    end
  endtask

  task automatic idle_chk(input int i);
    chk("cut_rst_idle", i, 32'(cut_v[i]), 1);
    chk("busy_idle", i, 32'(busy_v[i]), 0);
    chk("done_idle", i, 32'(done_v[i]), 0);
    chk("pass_idle", i, 32'(pass_v[i]), 0);
    chk("fail_idle", i, 32'(fail_v[i]), 0);
    chk("cap_idle", i, 32'(cap_v[i]), 0);
    chk("pass_cnt_idle", i, 32'(pc_v[i]), 0);
    chk("fail_cnt_idle", i, 32'(fc_v[i]), 0);
  endtask

  task automatic push(input int i, input logic [3:0] sig, input logic p, input logic [7:0] pc,
                      input logic [7:0] fc, input int dc);
    exp_t e;
    e.sig = sig; e.pass = p; e.fail = !p; e.pcnt = pc; e.fcnt = fc; e.done_cyc = dc;
    exp_q[i].push_back(e);
  endtask

  task automatic wait_empty(input int i, input int budget);
    for (int n = 0; n < budget && exp_q[i].size() != 0; n++) @(negedge clk);
    #1;
    total++;
    if (exp_q[i].size() != 0) begin
      bad++;
      $display("FAIL done_timeout[%0d]: got %0d pending results want 0", i, exp_q[i].size());
      exp_q[i].delete();
    end
  endtask

  task automatic pulse_pf();
    start_pf = 1'b1;
    @(negedge clk);
    start_pf = 1'b0;
  endtask

  // Monitor: invariants every cycle, full result compare on every rising done.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst) lo_cnt[i] = 0;
      else if (!cut_v[i]) lo_cnt[i]++;
      total++;
      if ((pass_v[i] && fail_v[i]) || ((pass_v[i] || fail_v[i]) && !done_v[i])) begin
        bad++;
        $display("FAIL excl[%0d]: got pass=%0b fail=%0b done=%0b want exclusive and only in DONE",
                 i, pass_v[i], fail_v[i], done_v[i]);
      end
      if (rst && done_v[i] && !done_q[i]) begin
        if (exp_q[i].size() == 0) begin
          chk("unexpected_done", i, 1, 0);
        end else begin
          exp_t e;
          e = exp_q[i].pop_front();
          chk("done_cycle", i, 32'(cyc), 32'(e.done_cyc));
          chk("cut_low_cycles", i, 32'(lo_cnt[i]), 17);
          chk("captured_sig", i, 32'(cap_v[i]), 32'(e.sig));
          chk("pass", i, 32'(pass_v[i]), 32'(e.pass));
          chk("fail", i, 32'(fail_v[i]), 32'(e.fail));
          chk("pass_cnt", i, 32'(pc_v[i]), 32'(e.pcnt));
          chk("fail_cnt", i, 32'(fc_v[i]), 32'(e.fcnt));
          chk("busy_done", i, 32'(busy_v[i]), 0);
          chk("cut_rst_done", i, 32'(cut_v[i]), 1);
          lo_cnt[i] = 0;
        end
      end
      done_q[i] = done_v[i];
    end
  end

  initial begin
    int c;
    for (int i = 0; i < 4; i++) begin
      lo_cnt[i] = 0;
      done_q[i] = 1'b0;
    end

    // Reset with start and sig_in toggling.
    repeat (4) begin
      @(negedge clk);
      start_pf = ~start_pf; start_sat = ~start_sat; start_int = ~start_int;
      noise = noise + 4'h7;
      #1;
      for (int i = 0; i < 4; i++) idle_chk(i);
    end
    @(negedge clk);
    start_pf = 1'b0; start_sat = 1'b0; start_int = 1'b0; noise = 4'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) idle_chk(i);

    // Pass and fail paths side by side.
    @(negedge clk);
    c = cyc;
    push(0, 4'h0, 1'b1, 8'd1, 8'd0, c + 19);
    push(1, 4'h0, 1'b0, 8'd0, 8'd1, c + 19);
    pulse_pf();
    wait_empty(0, 40);
    wait_empty(1, 5);

    // start re-asserted during RUN must not disturb the run.
    @(negedge clk);
    c = cyc;
    push(0, 4'h0, 1'b1, 8'd2, 8'd0, c + 19);
    push(1, 4'h0, 1'b0, 8'd0, 8'd2, c + 19);
    pulse_pf();
    repeat (5) @(negedge clk);
    pulse_pf();
    wait_empty(0, 40);
    wait_empty(1, 5);

    // Reset pulse when run_cnt = 8 aborts the run.
    @(negedge clk);
    c = cyc;
    pulse_pf();
    while (cyc < c + 10) @(negedge clk);
    chk("busy_run", 0, 32'(busy_v[0]), 1);
    chk("cut_rst_run", 0, 32'(cut_v[0]), 0);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) idle_chk(i);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    c = cyc;
    push(0, 4'h0, 1'b1, 8'd1, 8'd0, c + 19);
    push(1, 4'h0, 1'b0, 8'd0, 8'd1, c + 19);
    pulse_pf();
    wait_empty(0, 40);
    wait_empty(1, 5);

    // start held high: back-to-back runs, 2-bit tally saturates at 3.
    @(negedge clk);
    c = cyc;
    for (int k = 1; k <= 5; k++) push(2, 4'h0, 1'b1, 8'((k > 3) ? 3 : k), 8'd0, c + 19 * k);
    start_sat = 1'b1;
    while (cyc < c + 95) @(negedge clk);
    start_sat = 1'b0;
    wait_empty(2, 10);
    repeat (3) @(negedge clk);
    chk("done_hold", 2, 32'(done_v[2]), 1);
    chk("pass_cnt_sat", 2, 32'(pc_v[2]), 3);

    // Integration with the counter-fed MISR; its 16-edge signature is 4'hB.
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      c = cyc;
      push(3, 4'hB, 1'b1, 8'(k), 8'd0, c + 19);
      start_int = 1'b1;
      @(negedge clk);
      start_int = 1'b0;
      wait_empty(3, 40);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
